// File: rtl/fighter_anim_sequencer_if.sv
// Pose request channel between the game-logic FSM and the fighter animation sequencer.
//   pose_req    requested pose index
//   pose_valid  request strobe from the game logic
//   pose_ready  sequencer can take a request (valid & ready = accepted)
// master: game-logic side; slave: sequencer side.

interface fighter_anim_sequencer_if #(
  parameter int unsigned POSE_W = 3
) ();

  logic [POSE_W-1:0] pose_req;
  logic              pose_valid;
  logic              pose_ready;

  modport master (
    output pose_req,
    output pose_valid,
    input  pose_ready
  );

  modport slave (
    input  pose_req,
    input  pose_valid,
    output pose_ready
  );

endinterface

// File: rtl/fighter_anim_sequencer.sv
// Fighter sprite animation sequencer. Picks one of NUM_POSES pose channels per pixel and steps
// the displayed pose through FRAMES animation frames. Pose changes land only on frame_tick so a
// video frame never tears. Poses can be looping, one-shot, locked one-shot or terminal.
// Ports:
//   vga_clk, reset_n   pixel clock, async active-low reset
//   frame_tick         1-cycle pulse per video frame
//   req_if (slave)     pose_req / pose_valid / pose_ready request channel
//   blank              1 = active video, 0 forces colour/sprite_on to zero
//   pix_rgb, pix_on    per-pose {r,g,b} and sprite hit from the pose ROMs
//   frame_sel          frame index driven to every pose ROM
//   cur_pose           pose currently displayed
//   red/green/blue     registered colour of the selected pose
//   sprite_on          registered sprite hit of the selected pose
//   anim_done          pulse when a non-terminal one-shot finishes
//   req_err            pulse when an accepted request names a pose that does not exist

module fighter_anim_sequencer #(
  parameter int unsigned          NUM_POSES    = 8,
  parameter int unsigned          FRAMES       = 4,
  parameter int unsigned          FRAME_HOLD   = 6,
  parameter int unsigned          COLOR_W      = 4,
  parameter int unsigned          DEFAULT_POSE = 0,
  parameter logic [NUM_POSES-1:0] ONESHOT_MASK = 8'hCA,
  parameter logic [NUM_POSES-1:0] LOCK_MASK    = 8'hC2,
  parameter logic [NUM_POSES-1:0] TERM_MASK    = 8'h40,
  localparam int unsigned         POSE_W       = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1,
  localparam int unsigned         FRAME_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                           vga_clk,
  input  logic                           reset_n,
  input  logic                           frame_tick,
  fighter_anim_sequencer_if.slave        req_if,
  input  logic                           blank,
  input  logic [NUM_POSES*3*COLOR_W-1:0] pix_rgb,
  input  logic [NUM_POSES-1:0]           pix_on,
  output logic [FRAME_W-1:0]             frame_sel,
  output logic [POSE_W-1:0]              cur_pose,
  output logic [COLOR_W-1:0]             red,
  output logic [COLOR_W-1:0]             green,
  output logic [COLOR_W-1:0]             blue,
  output logic                           sprite_on,
  output logic                           anim_done,
  output logic                           req_err
);

  localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  // Masks widened to every encodable pose index so indexing by a POSE_W value is always legal.
  localparam int unsigned NSEL   = 1 << POSE_W;

  localparam logic [NSEL-1:0]    OS_M       = NSEL'(ONESHOT_MASK);
  localparam logic [NSEL-1:0]    LOCK_M     = NSEL'(LOCK_MASK);
  localparam logic [NSEL-1:0]    TERM_M     = NSEL'(TERM_MASK);
  localparam logic [POSE_W-1:0]  DEF_POSE   = POSE_W'(DEFAULT_POSE);
  localparam logic [POSE_W:0]    POSE_LIMIT = (POSE_W+1)'(NUM_POSES);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);

  typedef enum logic [1:0] {StLoop, StOneshot, StTerminal} state_e;

  state_e              state_q, state_d;
  logic [POSE_W-1:0]   cur_pose_q, cur_pose_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [POSE_W-1:0]   pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                anim_done_q, anim_done_d;
  logic                req_err_q, req_err_d;
  logic [COLOR_W-1:0]  red_q, green_q, blue_q;
  logic                sprite_on_q;

  logic                pose_ready;
  logic                req_bad;
  logic [POSE_W-1:0]   next_pose;
  logic [3*COLOR_W-1:0] sel_rgb;
  logic                sel_on;

  assign pose_ready        = !pend_valid_q && (state_q != StTerminal);
  assign req_if.pose_ready = pose_ready;
  assign req_bad           = {1'b0, req_if.pose_req} >= POSE_LIMIT;
  // Pose loaded when a one-shot runs out: a queued request wins over the idle pose.
  assign next_pose         = pend_valid_q ? pend_q : DEF_POSE;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StLoop;
      cur_pose_q   <= DEF_POSE;
      frame_q      <= '0;
      hold_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      anim_done_q  <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_pose_q   <= cur_pose_d;
      frame_q      <= frame_d;
      hold_q       <= hold_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      anim_done_q  <= anim_done_d;
      req_err_q    <= req_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_pose_d   = cur_pose_q;
    frame_d      = frame_q;
    hold_d       = hold_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    anim_done_d  = 1'b0;
    req_err_d    = 1'b0;

    if (frame_tick && (state_q != StTerminal)) begin
      if (pend_valid_q && !((state_q == StOneshot) && LOCK_M[cur_pose_q])) begin
        pend_valid_d = 1'b0;
        // Re-requesting the looping pose is absorbed without restarting its animation.
        if (!((state_q == StLoop) && (pend_q == cur_pose_q))) begin
          cur_pose_d = pend_q;
          frame_d    = '0;
          hold_d     = '0;
          state_d    = OS_M[pend_q] ? StOneshot : StLoop;
        end
      end else if (hold_q < HOLD_LAST) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = '0;
        case (state_q)
          StLoop: begin
            frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FRAME_W'(1);
          end
          StOneshot: begin
            if (frame_q != LAST_FRAME) begin
              frame_d = frame_q + FRAME_W'(1);
            end else if (TERM_M[cur_pose_q]) begin
              state_d = StTerminal;
            end else begin
              anim_done_d  = 1'b1;
              cur_pose_d   = next_pose;
              frame_d      = '0;
              pend_valid_d = 1'b0;
              state_d      = OS_M[next_pose] ? StOneshot : StLoop;
            end
          end
          default: ;
        endcase
      end
    end

    // Accept after the tick logic: ready implies nothing was pending this cycle, so a request
    // accepted alongside frame_tick waits for the following tick.
    if (req_if.pose_valid && pose_ready) begin
      if (req_bad) begin
        req_err_d = 1'b1;
      end else begin
        pend_d       = req_if.pose_req;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Channel select; indices at or above NUM_POSES are never matched.
  always_comb begin
    sel_rgb = '0;
    sel_on  = 1'b0;
    for (int p = 0; p < NUM_POSES; p++) begin
      if (cur_pose_q == POSE_W'(p)) begin
        sel_rgb = pix_rgb[p*3*COLOR_W +: 3*COLOR_W];
        sel_on  = pix_on[p];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      sprite_on_q <= 1'b0;
    end else if (blank) begin
      red_q       <= sel_rgb[3*COLOR_W-1 -: COLOR_W];
      green_q     <= sel_rgb[2*COLOR_W-1 -: COLOR_W];
      blue_q      <= sel_rgb[COLOR_W-1:0];
      sprite_on_q <= sel_on;
    end else begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      sprite_on_q <= 1'b0;
    end
  end

  assign frame_sel = frame_q;
  assign cur_pose  = cur_pose_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign sprite_on = sprite_on_q;
  assign anim_done = anim_done_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_fighter_anim_sequencer.sv
// Directed bench for fighter_anim_sequencer: default 8-pose instance plus a 6-pose instance used
// to reach out-of-range request indices.

module tb_fighter_anim_sequencer;

  localparam int unsigned NP  = 8;
  localparam int unsigned NP2 = 6;
  localparam int unsigned CW  = 4;

  logic vga_clk = 1'b0;
  logic reset_n;
  logic frame_tick;
  logic blank;
  logic [NP*3*CW-1:0]  pix_rgb;
  logic [NP-1:0]       pix_on;
  logic [NP2*3*CW-1:0] pix_rgb2;
  logic [NP2-1:0]      pix_on2;

  logic [1:0]    frame_sel, frame_sel2;
  logic [2:0]    cur_pose, cur_pose2;
  logic [CW-1:0] red, green, blue, red2, green2, blue2;
  logic          sprite_on, anim_done, req_err;
  logic          sprite_on2, anim_done2, req_err2;

  int vectors    = 0;
  int miscompares = 0;

  fighter_anim_sequencer_if #(.POSE_W(3)) req_if ();
  fighter_anim_sequencer_if #(.POSE_W(3)) req_if2 ();

  fighter_anim_sequencer dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .req_if     (req_if),
    .blank      (blank),
    .pix_rgb    (pix_rgb),
    .pix_on     (pix_on),
    .frame_sel  (frame_sel),
    .cur_pose   (cur_pose),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .sprite_on  (sprite_on),
    .anim_done  (anim_done),
    .req_err    (req_err)
  );

  fighter_anim_sequencer #(
    .NUM_POSES    (NP2),
    .ONESHOT_MASK (6'h0A),
    .LOCK_MASK    (6'h02),
    .TERM_MASK    (6'h00)
  ) dut6 (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .req_if     (req_if2),
    .blank      (blank),
    .pix_rgb    (pix_rgb2),
    .pix_on     (pix_on2),
    .frame_sel  (frame_sel2),
    .cur_pose   (cur_pose2),
    .red        (red2),
    .green      (green2),
    .blue       (blue2),
    .sprite_on  (sprite_on2),
    .anim_done  (anim_done2),
    .req_err    (req_err2)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // One-cycle frame_tick; samples just after the edge that consumed it.
  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      step();
    end
  endtask

  task automatic req(input logic [2:0] p);
    req_if.pose_req   = p;
    req_if.pose_valid = 1'b1;
    step();
    req_if.pose_valid = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b1;
    frame_tick         = 1'b0;
    blank              = 1'b0;
    pix_on             = '0;
    pix_on2            = '0;
    pix_rgb2           = '0;
    req_if.pose_req    = '0;
    req_if.pose_valid  = 1'b0;
    req_if2.pose_req   = '0;
    req_if2.pose_valid = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pix_rgb[p*12 +: 12] = {4'(p), 4'(p + 1), 4'(p + 2)};
    end
    #1 reset_n = 1'b0;
    #11;

    // Reset state
    chk("rst_pose", cur_pose, 0);
    chk("rst_frame", frame_sel, 0);
    chk("rst_red", red, 0);
    chk("rst_sprite_on", sprite_on, 0);
    chk("rst_anim_done", anim_done, 0);
    chk("rst_req_err", req_err, 0);
    chk("rst_ready", req_if.pose_ready, 1);
    reset_n = 1'b1;
    step();

    // T1: idle loop, frame advances every 6th tick and wraps after frame 3
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk("t1_frame", frame_sel, (t / 6) % 4);
      step();
    end
    chk("t1_pose", cur_pose, 0);

    // T2: looping pose 5 waits for the next tick
    req(3'd5);
    chk("t2_ready_pend", req_if.pose_ready, 0);
    chk("t2_pose_hold", cur_pose, 0);
    chk("t2_req_err", req_err, 0);
    repeat (3) step();
    chk("t2_pose_hold2", cur_pose, 0);
    tick();
    chk("t2_pose", cur_pose, 5);
    chk("t2_frame", frame_sel, 0);
    chk("t2_ready", req_if.pose_ready, 1);
    step();

    // T3: locked one-shot 1 is not interrupted by a request for 4
    req(3'd1);
    tick();
    chk("t3_pose1", cur_pose, 1);
    chk("t3_frame0", frame_sel, 0);
    step();
    ticks(6);
    chk("t3_frame1", frame_sel, 1);
    req(3'd4);
    chk("t3_ready_pend", req_if.pose_ready, 0);
    ticks(17);
    chk("t3_pose_locked", cur_pose, 1);
    chk("t3_frame3", frame_sel, 3);
    chk("t3_no_done", anim_done, 0);
    tick();
    chk("t3_done", anim_done, 1);
    chk("t3_pose4", cur_pose, 4);
    chk("t3_frame_restart", frame_sel, 0);
    chk("t3_ready", req_if.pose_ready, 1);
    step();
    chk("t3_done_pulse", anim_done, 0);

    // Unlocked one-shot 3 is interrupted, then replays and ends on the idle pose
    req(3'd3);
    tick();
    chk("t3b_pose3", cur_pose, 3);
    step();
    ticks(6);
    chk("t3b_frame1", frame_sel, 1);
    req(3'd5);
    tick();
    chk("t3b_interrupt", cur_pose, 5);
    chk("t3b_int_frame", frame_sel, 0);
    step();
    req(3'd3);
    tick();
    chk("t3b_pose3_again", cur_pose, 3);
    step();

    // T5: pixel path on pose 3, one-cycle latency, blank gating
    pix_rgb[3*12 +: 12] = 12'hF0A;
    pix_on = 8'h08;
    blank  = 1'b1;
    chk("t5_latency", red, 0);
    step();
    chk("t5_red", red, 4'hF);
    chk("t5_green", green, 4'h0);
    chk("t5_blue", blue, 4'hA);
    chk("t5_on", sprite_on, 1);
    blank = 1'b0;
    step();
    chk("t5_blank_red", red, 0);
    chk("t5_blank_blue", blue, 0);
    chk("t5_blank_on", sprite_on, 0);
    blank  = 1'b1;
    pix_on = 8'hF7;
    step();
    chk("t5_sel_red", red, 4'hF);
    chk("t5_sel_on", sprite_on, 0);
    pix_on = 8'h08;

    ticks(23);
    chk("t3b_last_frame", frame_sel, 3);
    tick();
    chk("t3b_done", anim_done, 1);
    chk("t3b_default", cur_pose, 0);
    chk("t3b_frame0", frame_sel, 0);
    step();

    // T4: terminal pose 6 freezes on frame 3
    req(3'd6);
    tick();
    chk("t4_pose6", cur_pose, 6);
    step();
    ticks(23);
    chk("t4_frame3", frame_sel, 3);
    chk("t4_ready_pre", req_if.pose_ready, 1);
    tick();
    chk("t4_term_frame", frame_sel, 3);
    chk("t4_term_ready", req_if.pose_ready, 0);
    chk("t4_no_done", anim_done, 0);
    step();
    ticks(10);
    chk("t4_frozen_frame", frame_sel, 3);
    chk("t4_frozen_pose", cur_pose, 6);
    req(3'd2);
    tick();
    chk("t4_ignore_req", cur_pose, 6);
    pix_on = 8'hFF;
    step();
    chk("t4_red6", red, 6);
    chk("t4_on6", sprite_on, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t4_async_pose", cur_pose, 0);
    chk("t4_async_frame", frame_sel, 0);
    chk("t4_async_red", red, 0);
    chk("t4_async_on", sprite_on, 0);
    chk("t4_async_ready", req_if.pose_ready, 1);
    #2 reset_n = 1'b1;
    step();
    chk("t4_after_pose", cur_pose, 0);
    chk("t4_after_green", green, 1);

    // T6: out-of-range request on the 6-pose instance
    req_if2.pose_req   = 3'd7;
    req_if2.pose_valid = 1'b1;
    step();
    req_if2.pose_valid = 1'b0;
    chk("t6_err", req_err2, 1);
    chk("t6_not_stored", req_if2.pose_ready, 1);
    step();
    chk("t6_err_pulse", req_err2, 0);
    tick();
    chk("t6_pose_hold", cur_pose2, 0);
    req_if2.pose_req   = 3'd5;
    req_if2.pose_valid = 1'b1;
    step();
    req_if2.pose_valid = 1'b0;
    chk("t6_ok_no_err", req_err2, 0);
    chk("t6_ok_pend", req_if2.pose_ready, 0);
    tick();
    chk("t6_ok_pose", cur_pose2, 5);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
